// File: rtl/dpsk_phase_mapper.sv
// DPSK phase mapper: differential bit encoding, 0/180 degree carrier offset, and symbol timing.
// rom_addr lags phase_acc by one clock; a bit is accepted only in IDLE or on the symbol-boundary cycle.
module dpsk_phase_mapper #(
    parameter logic [15:0] SYM_LEN = 16'd1000,
    parameter int          ADDR_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [15:0]       phase_acc_i,
    input  logic              bit_in_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              enc_bit_o,
    output logic              sym_strobe_o,
    output logic              underrun_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [15:0]       cnt_q;
    logic              enc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              strobe_q;
    logic              underrun_q;

    logic              boundary;
    logic              hs;
    logic [15:0]       off;
    logic [ADDR_W-1:0] addr_d;

    assign boundary = (state_q == RUN) && (cnt_q == SYM_LEN - 16'd1);
    assign bit_ready_o = (state_q == IDLE) || boundary;
    assign hs = bit_valid_i && bit_ready_o;

    // 180-degree offset is a half-turn of the 16-bit phase; the carry out is discarded.
    assign off = phase_acc_i + (enc_q ? 16'h8000 : 16'h0000);
    assign addr_d = off[15 -: ADDR_W];

    generate
        if (ADDR_W < 16) begin : g_lsb_drop
            logic unused_lsbs;
            assign unused_lsbs = &{1'b0, off[15-ADDR_W:0]};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            enc_q      <= 1'b0;
            addr_q     <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            strobe_q <= hs;
            case (state_q)
                IDLE: begin
                    cnt_q <= 16'd0;
                    if (hs) begin
                        enc_q   <= enc_q ^ bit_in_i;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        cnt_q <= 16'd0;
                        if (bit_valid_i) begin
                            enc_q <= enc_q ^ bit_in_i;
                        end else begin
                            underrun_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr_o   = addr_q;
    assign enc_bit_o    = enc_q;
    assign sym_strobe_o = strobe_q;
    assign underrun_o   = underrun_q;
    assign busy_o       = (state_q == RUN);

endmodule
